// File: rtl/mpeg_mem_pkg.sv
// Shared constants for the MPEG core memory map and the shared mailbox RAM.
package mpeg_mem_pkg;

  localparam int SHARED_ADDR_WIDTH = 12;
  localparam int SHARED_DATA_WIDTH = 32;
  localparam int SHARED_NUM_BYTES  = SHARED_DATA_WIDTH / 8;

  // Top address nibble selecting a region in either core's address space.
  typedef enum logic [3:0] {
    REGION_PRIVATE = 4'h0,
    REGION_IO      = 4'h1,
    REGION_SHARED  = 4'h4,
    REGION_DDR     = 4'h5
  } mem_region_t;

endpackage

// File: rtl/shared_ram_byte_lane.sv
// One 8-bit lane of the shared RAM: true dual port, read-first, registered outputs.
module shared_ram_byte_lane #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [7:0]            data_in1,
  output logic [7:0]            data_out1,
  input  logic                  we2,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [7:0]            data_in2,
  output logic [7:0]            data_out2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // Both ports read the old word and then write; port 1 is applied last so it wins a same-address write.
  always_ff @(posedge clk) begin
    data_out1 <= mem[addr1];
    data_out2 <= mem[addr2];
    if (we2) begin
      mem[addr2] <= data_in2;
    end
    if (we1) begin
      mem[addr1] <= data_in1;
    end
  end

endmodule

// File: rtl/shared_dual_port_ram.sv
// Byte-writable true dual-port mailbox RAM shared by the main MPEG core (port 1)
// and the macroblock worker (port 2). Built from independent byte lanes.
module shared_dual_port_ram
  import mpeg_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = SHARED_ADDR_WIDTH,
  parameter int DATA_WIDTH = SHARED_DATA_WIDTH,
  parameter int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  we1,
  input  logic [NB-1:0]         be1,
  output logic [DATA_WIDTH-1:0] data_out1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic                  we2,
  input  logic [NB-1:0]         be2,
  output logic [DATA_WIDTH-1:0] data_out2
);

  logic                  collide;
  logic [NB-1:0]         be2_masked;
  logic [DATA_WIDTH-1:0] lane_out1;
  logic [DATA_WIDTH-1:0] lane_out2;
  logic                  reset_q;

  // Port 1 owns any lane both ports write at the same address, so port 2 drops those lanes.
  always_comb begin
    collide    = we1 && we2 && (addr1 == addr2);
    be2_masked = be2;
    if (collide) begin
      be2_masked = be2 & ~be1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    shared_ram_byte_lane #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk      (clk),
      .we1      (we1 && be1[i]),
      .addr1    (addr1),
      .data_in1 (data_in1[8*i +: 8]),
      .data_out1(lane_out1[8*i +: 8]),
      .we2      (we2 && be2_masked[i]),
      .addr2    (addr2),
      .data_in2 (data_in2[8*i +: 8]),
      .data_out2(lane_out2[8*i +: 8])
    );
  end

  // Remember whether the last edge saw reset; the lane registers stay plain so they map onto
  // block RAM outputs, and this flag forces the visible read data to zero for that cycle.
  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  assign data_out1 = reset_q ? '0 : lane_out1;
  assign data_out2 = reset_q ? '0 : lane_out2;

endmodule

// File: tb/tb_shared_dual_port_ram.sv
// Self-checking bench for shared_dual_port_ram with a word-level reference model.
module tb_shared_dual_port_ram;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] data_in1, data_in2;
  logic          we1, we2;
  logic [NB-1:0] be1, be2;
  logic [DW-1:0] data_out1, data_out2;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp1, exp2;
  int checks = 0;
  int errors = 0;

  shared_dual_port_ram dut (
    .clk(clk), .reset(reset),
    .addr1(addr1), .data_in1(data_in1), .we1(we1), .be1(be1), .data_out1(data_out1),
    .addr2(addr2), .data_in2(data_in2), .we2(we2), .be2(be2), .data_out2(data_out2)
  );

  always #5 clk = ~clk;

  // Drive one clock of stimulus and advance the model: outputs show the pre-write word
  // (or zero under reset); port 2 lanes are applied first so port 1 overrides shared lanes.
  task automatic cycle(input logic r,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic w1, input logic [NB-1:0] b1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2, input logic w2, input logic [NB-1:0] b2);
    reset = r;
    addr1 = a1; data_in1 = d1; we1 = w1; be1 = b1;
    addr2 = a2; data_in2 = d2; we2 = w2; be2 = b2;
    exp1 = r ? '0 : model_mem[a1];
    exp2 = r ? '0 : model_mem[a2];
    if (w2) for (int i = 0; i < NB; i++) if (b2[i]) model_mem[a2][8*i +: 8] = d2[8*i +: 8];
    if (w1) for (int i = 0; i < NB; i++) if (b1[i]) model_mem[a1][8*i +: 8] = d1[8*i +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cycle(1'b0, a1, '0, 1'b0, '0, a2, '0, 1'b0, '0);
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 12'h000, '0, 1'b0, '0, 12'h001, '0, 1'b0, '0);
      checks++;
      if (data_out1 !== 32'h0 || data_out2 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h/%h expected 00000000/00000000", data_out1, data_out2);
      end
    end
  endtask

  task automatic test_basic;
    cycle(1'b0, 12'h010, 32'hDEADBEEF, 1'b1, 4'hF, 12'h000, '0, 1'b0, '0);
    rd(12'h000, 12'h010);
    checks++;
    if (data_out2 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL basic_read_p2: got %h expected DEADBEEF", data_out2);
    end
  endtask

  task automatic test_byte_enables;
    cycle(1'b0, 12'h020, 32'h11223344, 1'b1, 4'hF, 12'h000, '0, 1'b0, '0);
    cycle(1'b0, 12'h000, '0, 1'b0, '0, 12'h020, 32'hAABBCCDD, 1'b1, 4'b0101);
    rd(12'h020, 12'h020);
    checks++;
    if (data_out1 !== 32'h11BB33DD || data_out2 !== 32'h11BB33DD) begin
      errors++;
      $display("[TB] FAIL byte_enables: got %h/%h expected 11BB33DD", data_out1, data_out2);
    end
    // Write with be=0 must not disturb the word.
    cycle(1'b0, 12'h020, 32'hFFFFFFFF, 1'b1, 4'h0, 12'h000, '0, 1'b0, '0);
    rd(12'h000, 12'h020);
    checks++;
    if (data_out2 !== 32'h11BB33DD) begin
      errors++;
      $display("[TB] FAIL be_zero_noop: got %h expected 11BB33DD", data_out2);
    end
  endtask

  task automatic test_read_first;
    cycle(1'b0, 12'h030, 32'h0, 1'b1, 4'hF, 12'h000, '0, 1'b0, '0);
    cycle(1'b0, 12'h030, 32'h00000055, 1'b1, 4'h1, 12'h030, '0, 1'b0, '0);
    checks++;
    if (data_out1 !== 32'h0 || data_out2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read_first_old: got %h/%h expected 00000000", data_out1, data_out2);
    end
    rd(12'h030, 12'h030);
    checks++;
    if (data_out1 !== 32'h55 || data_out2 !== 32'h55) begin
      errors++;
      $display("[TB] FAIL read_first_new: got %h/%h expected 00000055", data_out1, data_out2);
    end
  endtask

  task automatic test_collision;
    cycle(1'b0, 12'h040, 32'h01020304, 1'b1, 4'h3, 12'h040, 32'hA0B0C0D0, 1'b1, 4'hE);
    rd(12'h040, 12'h040);
    checks++;
    if (data_out1 !== 32'hA0B00304 || data_out2 !== 32'hA0B00304) begin
      errors++;
      $display("[TB] FAIL collision: got %h/%h expected A0B00304", data_out1, data_out2);
    end
  endtask

  task automatic test_reset_preload;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 12'hFFF, 32'hCAFEF00D, 1'b1, 4'hF, 12'h010, '0, 1'b0, '0);
      checks++;
      if (data_out1 !== 32'h0 || data_out2 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold_%0d: got %h/%h expected 00000000", c, data_out1, data_out2);
      end
    end
    rd(12'hFFF, 12'h010);
    checks++;
    if (data_out1 !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL reset_preload: got %h expected CAFEF00D", data_out1);
    end
    checks++;
    if (data_out2 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL reset_retain: got %h expected DEADBEEF", data_out2);
    end
  endtask

  task automatic test_back_to_back;
    for (int a = 0; a < DEPTH + 2; a++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'(a);
      ra = AW'(a - 2);
      cycle(1'b0, wa, DW'(wa), (a < DEPTH), 4'hF, ra, '0, 1'b0, '0);
      if (a >= 2) begin
        checks++;
        if (data_out2 !== DW'(a - 2)) begin
          errors++;
          $display("[TB] FAIL stream_addr_%0d: got %h expected %h", a - 2, data_out2, DW'(a - 2));
        end
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++)
      cycle(1'b0, AW'(12'h100 + k), $urandom, 1'b1, 4'hF, 12'h000, '0, 1'b0, '0);
    for (int n = 0; n < 400; n++) begin
      cycle(1'b0, AW'(12'h100 + $urandom_range(0, 7)), $urandom, 1'($urandom), 4'($urandom),
                  AW'(12'h100 + $urandom_range(0, 7)), $urandom, 1'($urandom), 4'($urandom));
      if (!$isunknown(exp1)) begin
        checks++;
        if (data_out1 !== exp1) begin
          errors++;
          $display("[TB] FAIL random_p1_%0d: got %h expected %h", n, data_out1, exp1);
        end
      end
      if (!$isunknown(exp2)) begin
        checks++;
        if (data_out2 !== exp2) begin
          errors++;
          $display("[TB] FAIL random_p2_%0d: got %h expected %h", n, data_out2, exp2);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
    reset = 1'b1;
    addr1 = '0; data_in1 = '0; we1 = 1'b0; be1 = '0;
    addr2 = '0; data_in2 = '0; we2 = 1'b0; be2 = '0;
    #1;
    test_reset;
    test_basic;
    test_byte_enables;
    test_read_first;
    test_collision;
    test_reset_preload;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
